// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between the link master and the register-file target.
interface spi_slave_regfile_if;
  logic cs_n;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output cs_n, output sclk, output mosi, input miso, input miso_oe);
  modport slave  (input cs_n, input sclk, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target with an 8-bit register file.
// The SPI pins are oversampled in the clk domain. Each frame is 16 bits:
// a command byte (rw, addr) followed by one data byte. The local sideband
// reports committed writes and aborted frames.
module spi_slave_regfile #(
  parameter int          NUM_REGS = 16,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  spi_slave_regfile_if.slave spi,
  output logic        wr_valid,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_abort,
  input  logic [6:0]  dbg_addr,
  output logic [7:0]  dbg_data
);
  localparam int         AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREG = 8'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  // Synchronisers are deliberately left out of reset. While reset is held they
  // keep tracking the pins, so a cs_n that stays low across reset produces no
  // false falling edge afterwards.
  logic [2:0] cs_sync_q, sclk_sync_q;
  logic [1:0] mosi_sync_q;

  state_t     state_q;
  logic [4:0] bit_cnt_q;
  logic [6:0] rx_q;       // the 8th bit of each byte is taken live from mosi_s
  logic [6:0] tx_q;       // bits still to be sent after the one on miso_q
  logic       rw_q;
  logic [6:0] addr_q;
  logic       miso_q, miso_oe_q, wr_valid_q, abort_q;
  logic [6:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] regs_q [NUM_REGS];

  logic       cs_s, cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;
  logic [6:0] cmd_addr;
  logic [7:0] rd_val;
  logic       wr_ok;

  // Two-flop synchronisers, plus a third stage on cs_n and sclk for edge detection.
  always_ff @(posedge clk) begin
    cs_sync_q   <= {cs_sync_q[1:0], spi.cs_n};
    sclk_sync_q <= {sclk_sync_q[1:0], spi.sclk};
    mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
  end

  assign cs_s      = cs_sync_q[1];
  assign cs_fall   = cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise   = ~cs_sync_q[2] & cs_sync_q[1];
  assign sclk_rise = ~sclk_sync_q[2] & sclk_sync_q[1];
  assign sclk_fall = sclk_sync_q[2] & ~sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  // Read address and write eligibility for the frame being decoded.
  always_comb begin
    cmd_addr = {rx_q[5:0], mosi_s};
    rd_val   = ({1'b0, cmd_addr} < NREG) ? regs_q[cmd_addr[AW-1:0]] : 8'h00;
    wr_ok    = rw_q && (addr_q != 7'd0) && ({1'b0, addr_q} < NREG);
    dbg_data = ({1'b0, dbg_addr} < NREG) ? regs_q[dbg_addr[AW-1:0]] : 8'h00;
  end

  // Frame FSM with all SPI and sideband outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      abort_q    <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      miso_oe_q  <= ~cs_s;
      case (state_q)
        IDLE: if (cs_fall) begin
          state_q   <= CMD;
          bit_cnt_q <= '0;
          rx_q      <= '0;
        end
        CMD: if (cs_rise) begin
          state_q <= IDLE;
          abort_q <= 1'b1;
        end else if (sclk_rise) begin
          rx_q      <= {rx_q[5:0], mosi_s};
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            rw_q    <= rx_q[6];
            addr_q  <= cmd_addr;
            state_q <= DATA;
            // The first data bit goes out immediately. No shift happens on the next falling edge.
            if (!rx_q[6]) begin
              miso_q <= rd_val[7];
              tx_q   <= rd_val[6:0];
            end else begin
              tx_q   <= '0;
            end
          end
        end
        DATA: if (sclk_rise && bit_cnt_q == 5'd15) begin
          // The last bit wins over a simultaneous cs_n rise, so the frame completes.
          bit_cnt_q <= 5'd16;
          miso_q    <= 1'b0;
          state_q   <= cs_rise ? IDLE : DONE;
          if (wr_ok) begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= addr_q;
            wr_data_q  <= {rx_q, mosi_s};
          end
        end else if (cs_rise) begin
          state_q <= IDLE;
          abort_q <= 1'b1;
          miso_q  <= 1'b0;
        end else if (sclk_rise) begin
          rx_q      <= {rx_q[5:0], mosi_s};
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end else if (sclk_fall && bit_cnt_q >= 5'd9) begin
          miso_q <= tx_q[6];
          tx_q   <= {tx_q[5:0], 1'b0};
        end
        DONE: begin
          miso_q <= 1'b0;
          if (cs_rise) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Register file. The write lands on the cycle the wr_valid pulse is visible.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == 0) ? ID_VALUE : 8'h00;
    end else if (wr_valid_q) begin
      regs_q[wr_addr_q[AW-1:0]] <= wr_data_q;
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = miso_oe_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_abort = abort_q;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile. It drives mode-0 frames with sclk set to clk/16.
module tb_spi_slave_regfile;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_valid, frame_abort;
  logic [6:0] wr_addr, dbg_addr;
  logic [7:0] wr_data, dbg_data;

  spi_slave_regfile_if spi_if ();

  spi_slave_regfile dut (
    .clk(clk), .reset_n(reset_n), .spi(spi_if),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_abort(frame_abort), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int wr_cnt = 0, abort_cnt = 0;
  logic [6:0] last_addr = '0;
  logic [7:0] last_data = '0;
  logic oe_mid;

  // Sideband pulse monitor.
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (frame_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  // One frame. tx is left-aligned (bit 23 goes first) and rx collects miso at each rise.
  // If rst_at is a bit index, reset_n is pulsed for 2 clk before that bit's rising edge.
  task automatic xfer(input logic [23:0] tx, input int nbits, input int rst_at,
                      output logic [23:0] rx);
    rx = '0;
    spi_if.cs_n = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      spi_if.mosi = tx[23-i];
      if (i == rst_at) begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end
      half();
      rx = {rx[22:0], spi_if.miso};
      spi_if.sclk = 1'b1;
      if (i == 3) oe_mid = spi_if.miso_oe;
      half();
      spi_if.sclk = 1'b0;
    end
    half();
    spi_if.cs_n = 1'b1;
    spi_if.mosi = 1'b0;
    half();
    half();
  endtask

  logic [23:0] rx;
  int w0, a0;

  initial begin
    reset_n = 1'b0;
    spi_if.cs_n = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.mosi = 1'b0;
    dbg_addr = 7'd0;
    repeat (5) @(negedge clk);
    chk("rst_miso", spi_if.miso, 0);
    chk("rst_oe", spi_if.miso_oe, 0);
    chk("rst_wrv", wr_valid, 0);
    chk("rst_abort", frame_abort, 0);
    chk("rst_wraddr", wr_addr, 0);
    chk("rst_wrdata", wr_data, 0);
    chk("rst_id", dbg_data, 8'hA5);
    dbg_addr = 7'd5; #1;
    chk("rst_reg5", dbg_data, 8'h00);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: read the ID register
    w0 = wr_cnt;
    xfer(24'h000000, 16, -1, rx);
    chk("t1_read_id", rx[7:0], 8'hA5);
    chk("t1_cmd_miso", rx[15:8], 8'h00);
    chk("t1_oe_mid", oe_mid, 1);
    chk("t1_oe_after", spi_if.miso_oe, 0);
    chk("t1_no_wr", wr_cnt - w0, 0);

    // 2: write reg 3, read back
    w0 = wr_cnt;
    xfer(24'h835C00, 16, -1, rx);
    chk("t2_wr_cnt", wr_cnt - w0, 1);
    chk("t2_wr_addr", last_addr, 7'd3);
    chk("t2_wr_data", last_data, 8'h5C);
    xfer(24'h030000, 16, -1, rx);
    chk("t2_read3", rx[7:0], 8'h5C);
    dbg_addr = 7'd3; #1;
    chk("t2_dbg3", dbg_data, 8'h5C);

    // 3: writes to read-only and out-of-range addresses are dropped
    w0 = wr_cnt;
    xfer(24'h80FF00, 16, -1, rx);
    xfer(24'h901200, 16, -1, rx);
    chk("t3_no_wr", wr_cnt - w0, 0);
    xfer(24'h000000, 16, -1, rx);
    chk("t3_read0", rx[7:0], 8'hA5);
    xfer(24'h100000, 16, -1, rx);
    chk("t3_read16", rx[7:0], 8'h00);
    dbg_addr = 7'd16; #1;
    chk("t3_dbg16", dbg_data, 8'h00);

    // 4: abort after 11 bits, then a full write
    w0 = wr_cnt; a0 = abort_cnt;
    xfer(24'h85AA00, 11, -1, rx);
    chk("t4_abort", abort_cnt - a0, 1);
    chk("t4_no_wr", wr_cnt - w0, 0);
    dbg_addr = 7'd5; #1;
    chk("t4_reg5_kept", dbg_data, 8'h00);
    a0 = abort_cnt;
    xfer(24'h853300, 16, -1, rx);
    chk("t4_wr_cnt", wr_cnt - w0, 1);
    chk("t4_reg5", dbg_data, 8'h33);
    chk("t4_no_abort", abort_cnt - a0, 0);

    // 5: 20 clocks in one frame, so the extra bits are ignored
    w0 = wr_cnt; a0 = abort_cnt;
    xfer(24'h870FFF, 20, -1, rx);
    chk("t5_wr_cnt", wr_cnt - w0, 1);
    chk("t5_wr_data", last_data, 8'h0F);
    dbg_addr = 7'd7; #1;
    chk("t5_reg7", dbg_data, 8'h0F);
    chk("t5_no_abort", abort_cnt - a0, 0);
    xfer(24'h07FFFF, 20, -1, rx);
    chk("t5_read7", rx[11:4], 8'h0F);
    chk("t5_tail_miso", rx[3:0], 4'h0);

    // 6: reset in the middle of a write, with cs_n still low
    w0 = wr_cnt; a0 = abort_cnt;
    xfer(24'h897700, 16, 5, rx);
    chk("t6_no_wr", wr_cnt - w0, 0);
    chk("t6_no_abort", abort_cnt - a0, 0);
    dbg_addr = 7'd9; #1;
    chk("t6_reg9", dbg_data, 8'h00);
    dbg_addr = 7'd3; #1;
    chk("t6_reg3_rst", dbg_data, 8'h00);
    dbg_addr = 7'd5; #1;
    chk("t6_reg5_rst", dbg_data, 8'h00);
    dbg_addr = 7'd7; #1;
    chk("t6_reg7_rst", dbg_data, 8'h00);
    xfer(24'h897700, 16, -1, rx);
    chk("t6_fresh_wr", wr_cnt - w0, 1);
    dbg_addr = 7'd9; #1;
    chk("t6_reg9_new", dbg_data, 8'h77);
    xfer(24'h000000, 16, -1, rx);
    chk("t6_read_id", rx[7:0], 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
